mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

- Arbitrates the datapath's instruction-fetch port and data-access port onto one shared single-outstanding memory bus.
- Sits directly downstream of the CPU datapath, between its rom/ram request outputs and the memory/bridge.
- Handles one transaction at a time and registers read data back to the requesting side.
- Aborts any transaction that stalls past a configurable bus timeout.

## Interface
Parameters:
- TIMEOUT, 255: cycles a bus transaction may wait for `bus_ack_i` before it is aborted. 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-low (rst_i == 0 resets)
- inst_req_i  in  1  instruction fetch request; held until granted
- inst_addr_i  in  32  fetch address
- inst_gnt_o  out  1  request accepted this cycle (combinational)
- inst_rvalid_o  out  1  one-cycle pulse: fetch complete
- inst_rdata_o  out  32  fetched word, valid with inst_rvalid_o
- data_req_i  in  1  data access request; held until granted
- data_we_i  in  1  1 = write, 0 = read
- data_sel_i  in  4  byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  request accepted this cycle (combinational)
- data_rvalid_o  out  1  one-cycle pulse: read data valid, or write done
- data_rdata_o  out  32  read word (0 for writes)
- err_o  out  1  pulses with the rvalid of an aborted (timed-out) transaction
- bus_req_o  out  1  bus request, held until ack
- bus_we_o  out  1  write strobe
- bus_sel_o  out  4  byte enables
- bus_addr_o  out  32  address
- bus_wdata_o  out  32  write data
- bus_ack_i  in  1  transaction complete this cycle
- bus_rdata_i  in  32  read data, valid with bus_ack_i

## Operation

**FSM states:** IDLE, INST, DATA.

**IDLE**
- data_req_i=1 → assert data_gnt_o, latch data_we/sel/addr/wdata, go to DATA.
- Else inst_req_i=1 → assert inst_gnt_o, latch inst_addr_i (we=0, sel=4'hF, wdata=0), go to INST.
- Else stay in IDLE.
- Grants are asserted only in IDLE; at most one grant per cycle.

**INST / DATA**
- bus_req_o=1 with latched fields held stable.
- On bus_ack_i=1: register bus_rdata_i into the owner's rdata (data writes register 0), pulse the owner's rvalid next cycle, return to IDLE.

**Timeout**
- A counter clears on entry to INST/DATA and increments each busy cycle.
- When it reaches TIMEOUT without ack: return to IDLE and pulse the owner's rvalid with rdata=0 and err_o=1.

**Boundary rules**
- Ack and timeout in the same cycle: ack wins, err_o=0.
- Requests arriving while busy are not granted; they must be held by the requester.
- Ack while in IDLE is ignored.
- rdata outputs hold their last value between pulses.

## Timing

**Reset values** (rst_i=0 at a clock edge):
- State IDLE.
- All outputs 0: bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, inst_rvalid_o, data_rvalid_o, inst_rdata_o, data_rdata_o, err_o.
- Timeout counter 0.

**Reset mid-transaction:** bus_req_o drops the next cycle, no rvalid is produced, and the latched request is discarded.

**Latency:**
- Grant in cycle N; bus_req_o=1 from cycle N+1.
- Ack in cycle M ≥ N+1 → rvalid/rdata in cycle M+1.
- A new grant is possible in cycle M+1.
- Minimum is 3 cycles per transaction, request to rvalid inclusive of grant cycle.

**Counter width:** $clog2(TIMEOUT+1), saturating.

## Configuration
- **ARB_ROUND_ROBIN_EN defined:** when both requests are pending in IDLE, the side not granted most recently wins. The last-granted flag resets to "inst".
- **Undefined:** fixed priority, data always wins over inst.
- Single-requester behaviour is identical in both builds.

## Test plan
- **Single fetch:** inst_req_i=1, addr 0x0000_0040; ack 2 cycles after bus_req_o with rdata 0x2402_0001 → inst_gnt_o in cycle 0, bus_addr_o=0x40, bus_we_o=0, bus_sel_o=4'hF, inst_rvalid_o with rdata 0x2402_0001 one cycle after ack.
- **Data write:** data_req_i=1, we=1, sel=4'b0011, addr 0x1000, wdata 0xDEAD_BEEF; immediate ack → bus fields match, data_rvalid_o pulses with data_rdata_o=0, err_o=0.
- **Simultaneous requests, twice back-to-back:**
  - Fixed priority: data granted first both times.
  - With ARB_ROUND_ROBIN_EN: data then inst in the first pair, then alternating.
- **Timeout:** TIMEOUT=4, never ack → bus_req_o high 4 cycles, then data_rvalid_o=1, err_o=1, rdata 0, FSM idle. Repeat with ack on cycle 4 → err_o=0.
- **Reset mid-op:** drive rst_i=0 while bus_req_o=1 → next cycle all outputs 0, no rvalid; a new fetch after reset completes normally.
- **Stray ack:** bus_ack_i=1 in IDLE → no rvalid, no state change.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU datapath, mem_bus_arbiter and the shared memory bus.
// master: arbiter view. slave: environment view (datapath requesters plus memory).
interface mem_bus_arbiter_if;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic        inst_gnt_o;
  logic        inst_rvalid_o;
  logic [31:0] inst_rdata_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  logic        err_o;

  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    input  inst_req_i, inst_addr_i,
    input  data_req_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
    input  bus_ack_i, bus_rdata_i,
    output inst_gnt_o, inst_rvalid_o, inst_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output err_o,
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o
  );

  modport slave (
    output inst_req_i, inst_addr_i,
    output data_req_i, data_we_i, data_sel_i, data_addr_i, data_wdata_i,
    output bus_ack_i, bus_rdata_i,
    input  inst_gnt_o, inst_rvalid_o, inst_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  err_o,
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto one single-outstanding memory bus with ack timeout.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin instead of data-first priority.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_bus_arbiter_if.master  port
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INST = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          data_wins;
  logic          inst_gnt;
  logic          data_gnt;
  logic          timeout_hit;

  logic          bus_we;
  logic [3:0]    bus_sel;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic          inst_rvalid;
  logic          data_rvalid;
  logic [31:0]   inst_rdata;
  logic [31:0]   data_rdata;
  logic          err;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_inst;

  // On contention the side granted less recently wins.
  assign data_wins = !port.inst_req_i || last_inst;

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      last_inst <= 1'b1;
    else if (inst_gnt || data_gnt)
      last_inst <= inst_gnt;
  end
`else
  assign data_wins = 1'b1;
`endif

  assign busy     = (state != IDLE);
  assign data_gnt = rst_i && !busy && port.data_req_i && data_wins;
  assign inst_gnt = rst_i && !busy && port.inst_req_i && !data_gnt;

  // Counter holds the number of busy cycles already spent waiting for ack.
  assign timeout_hit = (TIMEOUT != 0) && busy && !port.bus_ack_i && (cnt == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_we      <= 1'b0;
      bus_sel     <= 4'h0;
      bus_addr    <= 32'h0;
      bus_wdata   <= 32'h0;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      inst_rdata  <= 32'h0;
      data_rdata  <= 32'h0;
      err         <= 1'b0;
    end else begin
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          if (data_gnt) begin
            state     <= DATA;
            cnt       <= '0;
            bus_we    <= port.data_we_i;
            bus_sel   <= port.data_sel_i;
            bus_addr  <= port.data_addr_i;
            bus_wdata <= port.data_wdata_i;
          end else if (inst_gnt) begin
            state     <= INST;
            cnt       <= '0;
            bus_we    <= 1'b0;
            bus_sel   <= 4'hF;
            bus_addr  <= port.inst_addr_i;
            bus_wdata <= 32'h0;
          end
        end
        INST, DATA: begin
          if (port.bus_ack_i) begin
            state <= IDLE;
            if (state == INST) begin
              inst_rvalid <= 1'b1;
              inst_rdata  <= port.bus_rdata_i;
            end else begin
              data_rvalid <= 1'b1;
              data_rdata  <= bus_we ? 32'h0 : port.bus_rdata_i;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
            err   <= 1'b1;
            if (state == INST) begin
              inst_rvalid <= 1'b1;
              inst_rdata  <= 32'h0;
            end else begin
              data_rvalid <= 1'b1;
              data_rdata  <= 32'h0;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign port.inst_gnt_o    = inst_gnt;
  assign port.data_gnt_o    = data_gnt;
  assign port.bus_req_o     = busy;
  assign port.bus_we_o      = bus_we;
  assign port.bus_sel_o     = bus_sel;
  assign port.bus_addr_o    = bus_addr;
  assign port.bus_wdata_o   = bus_wdata;
  assign port.inst_rvalid_o = inst_rvalid;
  assign port.inst_rdata_o  = inst_rdata;
  assign port.data_rvalid_o = data_rvalid;
  assign port.data_rdata_o  = data_rdata;
  assign port.err_o         = err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bif ();

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .port  (bif)
  );

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dsel;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        ack;
    logic [31:0] brdata;
    logic        e_igt;
    logic        e_dgt;
    logic        e_breq;
    logic        e_bwe;
    logic [3:0]  e_bsel;
    logic [31:0] e_baddr;
    logic [31:0] e_bwdata;
    logic        e_irv;
    logic        e_drv;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // so each call covers one cycle whose rising edge follows the sample point.
  task automatic drive(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [3:0] dsel,
                       input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic ack, input logic [31:0] brdata);
    @(negedge clk);
    bif.inst_req_i   = ireq;
    bif.inst_addr_i  = iaddr;
    bif.data_req_i   = dreq;
    bif.data_we_i    = dwe;
    bif.data_sel_i   = dsel;
    bif.data_addr_i  = daddr;
    bif.data_wdata_i = dwdata;
    bif.bus_ack_i    = ack;
    bif.bus_rdata_i  = brdata;
    #1;
  endtask

  task automatic idle_cycle(input logic ack);
    drive(0, 0, 0, 0, 0, 0, 0, ack, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " bus_req"},   bif.bus_req_o,     0);
    check({tag, " bus_we"},    bif.bus_we_o,      0);
    check({tag, " bus_sel"},   bif.bus_sel_o,     0);
    check({tag, " bus_addr"},  bif.bus_addr_o,    0);
    check({tag, " bus_wdata"}, bif.bus_wdata_o,   0);
    check({tag, " i_rvalid"},  bif.inst_rvalid_o, 0);
    check({tag, " d_rvalid"},  bif.data_rvalid_o, 0);
    check({tag, " i_rdata"},   bif.inst_rdata_o,  0);
    check({tag, " d_rdata"},   bif.data_rdata_o,  0);
    check({tag, " err"},       bif.err_o,         0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    idle_cycle(0);
    idle_cycle(0);
    check_all_zero(tag);
    rst = 1'b1;
  endtask

  vec_t vecs[15];

  // Reference model state (transaction level)
  bit          m_busy, m_own_data, m_we, m_last_inst;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  int          m_age;
  bit          m_rv_i, m_rv_d, m_err;

  initial begin
    idle_cycle(0);
    do_reset("reset");

    // Directed vectors: fetch, data write with held fetch behind it, stray ack, data read.
    vecs[0]  = '{1, 32'h40,   0,0,4'h0,32'h0,32'h0,          0,32'h0,       1,0,0, 0,4'h0,32'h0,0,    0,0,0,32'h0};
    vecs[1]  = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          0,32'h0,       0,0,1, 0,4'hF,32'h40,0,   0,0,0,32'h0};
    vecs[2]  = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          0,32'h0,       0,0,1, 0,4'hF,32'h40,0,   0,0,0,32'h0};
    vecs[3]  = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          1,32'h24020001,0,0,1, 0,4'hF,32'h40,0,   0,0,0,32'h0};
    vecs[4]  = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          0,32'h0,       0,0,0, 0,4'h0,32'h0,0,    1,0,0,32'h24020001};
    vecs[5]  = '{1, 32'h44,   1,1,4'h3,32'h1000,32'hDEADBEEF,0,32'h0,       0,1,0, 0,4'h0,32'h0,0,    0,0,0,32'h0};
    vecs[6]  = '{1, 32'h44,   0,0,4'h0,32'h0,32'h0,          1,32'h12345678,0,0,1, 1,4'h3,32'h1000,32'hDEADBEEF, 0,0,0,32'h0};
    vecs[7]  = '{1, 32'h44,   0,0,4'h0,32'h0,32'h0,          0,32'h0,       1,0,0, 0,4'h0,32'h0,0,    0,1,0,32'h0};
    vecs[8]  = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          1,32'hA5A5A5A5,0,0,1, 0,4'hF,32'h44,0,   0,0,0,32'h0};
    vecs[9]  = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          0,32'h0,       0,0,0, 0,4'h0,32'h0,0,    1,0,0,32'hA5A5A5A5};
    vecs[10] = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          1,32'hFFFFFFFF,0,0,0, 0,4'h0,32'h0,0,    0,0,0,32'h0};
    vecs[11] = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          0,32'h0,       0,0,0, 0,4'h0,32'h0,0,    0,0,0,32'h0};
    vecs[12] = '{0, 32'h0,    1,0,4'hF,32'h2000,32'h55,      0,32'h0,       0,1,0, 0,4'h0,32'h0,0,    0,0,0,32'h0};
    vecs[13] = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          1,32'hCAFEF00D,0,0,1, 0,4'hF,32'h2000,32'h55, 0,0,0,32'h0};
    vecs[14] = '{0, 32'h0,    0,0,4'h0,32'h0,32'h0,          0,32'h0,       0,0,0, 0,4'h0,32'h0,0,    0,1,0,32'hCAFEF00D};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].dsel,
            vecs[i].daddr, vecs[i].dwdata, vecs[i].ack, vecs[i].brdata);
      check($sformatf("vec%0d inst_gnt", i), bif.inst_gnt_o,    vecs[i].e_igt);
      check($sformatf("vec%0d data_gnt", i), bif.data_gnt_o,    vecs[i].e_dgt);
      check($sformatf("vec%0d bus_req", i),  bif.bus_req_o,     vecs[i].e_breq);
      check($sformatf("vec%0d i_rvalid", i), bif.inst_rvalid_o, vecs[i].e_irv);
      check($sformatf("vec%0d d_rvalid", i), bif.data_rvalid_o, vecs[i].e_drv);
      check($sformatf("vec%0d err", i),      bif.err_o,         vecs[i].e_err);
      if (vecs[i].e_breq) begin
        check($sformatf("vec%0d bus_we", i),    bif.bus_we_o,    vecs[i].e_bwe);
        check($sformatf("vec%0d bus_sel", i),   bif.bus_sel_o,   vecs[i].e_bsel);
        check($sformatf("vec%0d bus_addr", i),  bif.bus_addr_o,  vecs[i].e_baddr);
        check($sformatf("vec%0d bus_wdata", i), bif.bus_wdata_o, vecs[i].e_bwdata);
      end
      if (vecs[i].e_irv) check($sformatf("vec%0d i_rdata", i), bif.inst_rdata_o, vecs[i].e_rdata);
      if (vecs[i].e_drv) check($sformatf("vec%0d d_rdata", i), bif.data_rdata_o, vecs[i].e_rdata);
    end

    // Both sides requesting continuously; ack always high so a grant is possible every 2 cycles.
    do_reset("reset2");
    for (int k = 0; k < 8; k++) begin
      logic exp_i, exp_d;
      drive(1, 32'h100 + k, 1, 0, 4'hF, 32'h200 + k, 0, 1, 32'h77);
      exp_i = 1'b0;
      exp_d = 1'b0;
      if (k % 2 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = ((k / 2) % 2 == 0);
        exp_i = !exp_d;
`else
        exp_d = 1'b1;
`endif
      end
      check($sformatf("contend%0d inst_gnt", k), bif.inst_gnt_o, exp_i);
      check($sformatf("contend%0d data_gnt", k), bif.data_gnt_o, exp_d);
    end
    idle_cycle(0);

    // Timeout with no ack: four busy cycles then an error completion.
    drive(0, 0, 1, 0, 4'hF, 32'h3000, 0, 0, 0);
    check("to1 data_gnt", bif.data_gnt_o, 1);
    for (int k = 1; k <= TO; k++) begin
      idle_cycle(0);
      check($sformatf("to1 bus_req c%0d", k), bif.bus_req_o, 1);
      check($sformatf("to1 d_rvalid c%0d", k), bif.data_rvalid_o, 0);
    end
    idle_cycle(0);
    check("to1 bus_req end", bif.bus_req_o, 0);
    check("to1 d_rvalid",    bif.data_rvalid_o, 1);
    check("to1 err",         bif.err_o, 1);
    check("to1 d_rdata",     bif.data_rdata_o, 0);
    idle_cycle(0);
    check("to1 err clears",  bif.err_o, 0);
    check("to1 rdata holds", bif.data_rdata_o, 0);

    // Ack in the same cycle the timeout would fire: ack wins.
    drive(0, 0, 1, 0, 4'hF, 32'h3004, 0, 0, 0);
    check("to2 data_gnt", bif.data_gnt_o, 1);
    for (int k = 1; k < TO; k++) idle_cycle(0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h11112222);
    check("to2 bus_req ack cycle", bif.bus_req_o, 1);
    idle_cycle(0);
    check("to2 d_rvalid", bif.data_rvalid_o, 1);
    check("to2 err",      bif.err_o, 0);
    check("to2 d_rdata",  bif.data_rdata_o, 32'h11112222);

    // Reset while a fetch is on the bus.
    drive(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    check("rst inst_gnt", bif.inst_gnt_o, 1);
    idle_cycle(0);
    check("rst bus_req before", bif.bus_req_o, 1);
    rst = 1'b0;
    idle_cycle(0);
    check_all_zero("rst mid");
    rst = 1'b1;
    idle_cycle(1);
    check("rst post i_rvalid", bif.inst_rvalid_o, 0);
    check("rst post bus_req",  bif.bus_req_o, 0);
    drive(1, 32'h84, 0, 0, 0, 0, 0, 0, 0);
    check("rst refetch gnt", bif.inst_gnt_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
    check("rst refetch addr", bif.bus_addr_o, 32'h84);
    idle_cycle(0);
    check("rst refetch rvalid", bif.inst_rvalid_o, 1);
    check("rst refetch rdata",  bif.inst_rdata_o, 32'h99);

    // Randomized traffic against the reference model.
    do_reset("reset3");
    m_busy = 0; m_own_data = 0; m_we = 0; m_sel = 0; m_addr = 0; m_wdata = 0;
    m_irdata = 0; m_drdata = 0; m_age = 0; m_rv_i = 0; m_rv_d = 0; m_err = 0;
    m_last_inst = 1;
    begin
      logic        ireq, dreq, dwe, ack, gi, gd;
      logic [3:0]  dsel;
      logic [31:0] iaddr, daddr, dwdata, brdata;
      ireq = 0; dreq = 0; dwe = 0; dsel = 0; iaddr = 0; daddr = 0; dwdata = 0;
      for (int c = 0; c < 1500; c++) begin
        if (!ireq && ($urandom_range(2) == 0)) begin
          ireq  = 1;
          iaddr = $urandom;
        end
        if (!dreq && ($urandom_range(2) == 0)) begin
          dreq   = 1;
          dwe    = $urandom_range(1);
          dsel   = $urandom_range(15);
          daddr  = $urandom;
          dwdata = $urandom;
        end
        ack    = ($urandom_range(2) == 0);
        brdata = $urandom;
        drive(ireq, iaddr, dreq, dwe, dsel, daddr, dwdata, ack, brdata);

        // Policy: only an idle bus grants; on contention data wins, or with
        // round-robin the side that was not granted last time wins.
        gi = 0;
        gd = 0;
        if (!m_busy) begin
          if (ireq && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            gd = m_last_inst;
            gi = !m_last_inst;
`else
            gd = 1;
`endif
          end else begin
            gi = ireq;
            gd = dreq;
          end
        end

        check("rnd inst_gnt", bif.inst_gnt_o,    gi);
        check("rnd data_gnt", bif.data_gnt_o,    gd);
        check("rnd bus_req",  bif.bus_req_o,     m_busy);
        check("rnd i_rvalid", bif.inst_rvalid_o, m_rv_i);
        check("rnd d_rvalid", bif.data_rvalid_o, m_rv_d);
        check("rnd err",      bif.err_o,         m_err);
        check("rnd i_rdata",  bif.inst_rdata_o,  m_irdata);
        check("rnd d_rdata",  bif.data_rdata_o,  m_drdata);
        if (m_busy) begin
          check("rnd bus_we",    bif.bus_we_o,    m_we);
          check("rnd bus_sel",   bif.bus_sel_o,   m_sel);
          check("rnd bus_addr",  bif.bus_addr_o,  m_addr);
          check("rnd bus_wdata", bif.bus_wdata_o, m_wdata);
        end

        m_rv_i = 0;
        m_rv_d = 0;
        m_err  = 0;
        if (m_busy) begin
          m_age++;
          if (ack || m_age == TO) begin
            logic [31:0] rd;
            rd = (!ack || (m_own_data && m_we)) ? 32'h0 : brdata;
            m_err = !ack;
            if (m_own_data) begin m_rv_d = 1; m_drdata = rd; end
            else            begin m_rv_i = 1; m_irdata = rd; end
            m_busy = 0;
          end
        end else if (gd) begin
          m_busy = 1; m_own_data = 1; m_age = 0; m_last_inst = 0;
          m_we = dwe; m_sel = dsel; m_addr = daddr; m_wdata = dwdata;
          dreq = 0;
        end else if (gi) begin
          m_busy = 1; m_own_data = 0; m_age = 0; m_last_inst = 1;
          m_we = 0; m_sel = 4'hF; m_addr = iaddr; m_wdata = 0;
          ireq = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
